// File: rtl/ex_stage.sv
// Execute stage between ID/EX and EX/MEM: combinational ALU and branch resolution,
// plus an iterative shift-add multiplier that stalls ID/EX while it works.
module ex_stage #(
   parameter int WIDTH   = 32,
   parameter int MUL_BPC = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      next_pc,
   input  logic [13:0]      opcode,
   input  logic [WIDTH-1:0] rgS1_data,
   input  logic [WIDTH-1:0] rgS2_data,
   input  logic [WIDTH-1:0] immed,
   input  logic             y_sel,
   input  logic [5:0]       control,
   input  logic [4:0]       rgD_index,
   output logic             stall,
   output logic             out_valid,
   output logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] store_data,
   output logic [5:0]       control_out,
   output logic [4:0]       rgD_index_out,
   output logic             branch_taken,
   output logic [31:0]      branch_target
);

   localparam int STEPS = WIDTH / MUL_BPC;
   localparam int CW    = $clog2(STEPS + 1);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] mcand, mplier, product, mul_sum;
   logic [WIDTH-1:0] s2_hold;
   logic [5:0]       control_hold;
   logic [4:0]       rgd_hold;
   logic [3:0]       func;
   logic [WIDTH-1:0] b_op, alu_comb;
   logic             cond;
   logic             mul_start;

   assign func          = opcode[3:0];
   assign b_op          = y_sel ? immed : rgS2_data;
   assign mul_start     = (state == IDLE) && in_valid && (func == 4'h8);
   assign branch_target = next_pc + (32'(signed'(immed)) << 2);

   always_comb begin
      alu_comb = rgS1_data + b_op;
      cond     = 1'b0;
      case (func)
         4'h1: alu_comb = rgS1_data - b_op;
         4'h2: alu_comb = rgS1_data & b_op;
         4'h3: alu_comb = rgS1_data | b_op;
         4'h4: alu_comb = rgS1_data ^ b_op;
         4'h5: alu_comb = rgS1_data << b_op[4:0];
         4'h6: alu_comb = rgS1_data >> b_op[4:0];
         4'h7: alu_comb = {{(WIDTH-1){1'b0}}, ($signed(rgS1_data) < $signed(b_op))};
         4'h9: cond = (rgS1_data == rgS2_data);
         4'hA: cond = (rgS1_data != rgS2_data);
         default: ;
      endcase
   end

   // One multiplier step: add up to MUL_BPC shifted copies of the multiplicand.
   always_comb begin
      mul_sum = product;
      for (int j = 0; j < MUL_BPC; j++) begin
         if (mplier[j]) mul_sum = mul_sum + (mcand << j);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         count        <= '0;
         mcand        <= '0;
         mplier       <= '0;
         product      <= '0;
         s2_hold      <= '0;
         control_hold <= '0;
         rgd_hold     <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (mul_start) begin
                  mcand        <= rgS1_data;
                  mplier       <= b_op;
                  product      <= '0;
                  count        <= '0;
                  s2_hold      <= rgS2_data;
                  control_hold <= control;
                  rgd_hold     <= rgD_index;
               end
            end
            BUSY: begin
               product <= mul_sum;
               mcand   <= mcand << MUL_BPC;
               mplier  <= mplier >> MUL_BPC;
               count   <= count + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // DONE is never a MUL-detect point, so the still-held MUL opcode cannot restart it.
   always_comb begin
      state_next    = state;
      stall         = 1'b0;
      out_valid     = 1'b0;
      alu_result    = alu_comb;
      store_data    = rgS2_data;
      control_out   = '0;
      rgD_index_out = rgD_index;
      branch_taken  = 1'b0;
      case (state)
         IDLE: begin
            if (mul_start) begin
               state_next = BUSY;
               stall      = 1'b1;
            end else begin
               out_valid    = in_valid;
               control_out  = in_valid ? control : 6'd0;
               branch_taken = in_valid && control[4] && cond;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (count == LAST) state_next = DONE;
         end
         DONE: begin
            state_next    = IDLE;
            out_valid     = 1'b1;
            alu_result    = product;
            store_data    = s2_hold;
            control_out   = control_hold;
            rgD_index_out = rgd_hold;
         end
         default: state_next = IDLE;
      endcase
      if (!reset) begin
         stall        = 1'b0;
         out_valid    = 1'b0;
         control_out  = '0;
         branch_taken = 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, branches, multiplier timing and mid-MUL reset.
module tb_ex_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [31:0] next_pc;
   logic [13:0] opcode;
   logic [31:0] rgS1_data, rgS2_data, immed;
   logic        y_sel;
   logic [5:0]  control;
   logic [4:0]  rgD_index;
   logic        stall, out_valid, branch_taken;
   logic [31:0] alu_result, store_data, branch_target;
   logic [5:0]  control_out;
   logic [4:0]  rgD_index_out;

   int vectors    = 0;
   int miscompares = 0;
   int n;

   ex_stage #(.WIDTH(32), .MUL_BPC(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .next_pc(next_pc),
      .opcode(opcode), .rgS1_data(rgS1_data), .rgS2_data(rgS2_data),
      .immed(immed), .y_sel(y_sel), .control(control), .rgD_index(rgD_index),
      .stall(stall), .out_valid(out_valid), .alu_result(alu_result),
      .store_data(store_data), .control_out(control_out),
      .rgD_index_out(rgD_index_out), .branch_taken(branch_taken),
      .branch_target(branch_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [13:0] op,
                                input logic [31:0] a, input logic [31:0] s2,
                                input logic [31:0] imm, input logic ys,
                                input logic [5:0] ctrl, input logic [4:0] rd,
                                input logic [31:0] npc);
      in_valid  = v;
      opcode    = op;
      rgS1_data = a;
      rgS2_data = s2;
      immed     = imm;
      y_sel     = ys;
      control   = ctrl;
      rgD_index = rd;
      next_pc   = npc;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Counts stall cycles from the MUL issue cycle until the DONE cycle.
   task automatic waitMul(output int cycles);
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (!stall) break;
         cycles++;
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      reset = 1'b0;
      applyStimulus(1'b0, 14'h0, 32'h0, 32'h0, 32'h0, 1'b0, 6'h0, 5'd0, 32'h0);
      #10;
      checkOutput("reset_stall", {31'd0, stall}, 32'd0);
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_branch", {31'd0, branch_taken}, 32'd0);
      checkOutput("reset_control_out", {26'd0, control_out}, 32'd0);
      tick();
      reset = 1'b1;

      tick();
      applyStimulus(1'b1, 14'h0, 32'd5, 32'd99, 32'd7, 1'b1, 6'h08, 5'd3, 32'h0);
      checkOutput("add_result", alu_result, 32'd12);
      checkOutput("add_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("add_stall", {31'd0, stall}, 32'd0);
      checkOutput("add_control_out", {26'd0, control_out}, 32'h08);
      checkOutput("add_rgd", {27'd0, rgD_index_out}, 32'd3);

      tick();
      applyStimulus(1'b1, 14'h1, 32'd3, 32'd5, 32'd0, 1'b0, 6'h08, 5'd4, 32'h0);
      checkOutput("sub_result", alu_result, 32'hFFFF_FFFE);
      checkOutput("sub_store_data", store_data, 32'd5);

      tick();
      applyStimulus(1'b1, 14'h7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 6'h08, 5'd4, 32'h0);
      checkOutput("slt_result", alu_result, 32'd1);

      tick();
      applyStimulus(1'b1, 14'h5, 32'd1, 32'd0, 32'd31, 1'b1, 6'h08, 5'd4, 32'h0);
      checkOutput("sll_result", alu_result, 32'h8000_0000);

      tick();
      applyStimulus(1'b1, 14'h6, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 6'h08, 5'd4, 32'h0);
      checkOutput("srl_result", alu_result, 32'h0800_0000);

      tick();
      applyStimulus(1'b1, 14'h3F04, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 6'h08, 5'd4, 32'h0);
      checkOutput("xor_result", alu_result, 32'h0000_0FF0);

      tick();
      applyStimulus(1'b1, 14'h000B, 32'd2, 32'd3, 32'd0, 1'b0, 6'h08, 5'd4, 32'h0);
      checkOutput("undef_is_add", alu_result, 32'd5);

      tick();
      applyStimulus(1'b1, 14'h9, 32'd9, 32'd9, 32'd3, 1'b1, 6'h10, 5'd0, 32'h100);
      checkOutput("beq_taken", {31'd0, branch_taken}, 32'd1);
      checkOutput("beq_target", branch_target, 32'h10C);

      tick();
      applyStimulus(1'b1, 14'h9, 32'd9, 32'd8, 32'd3, 1'b1, 6'h10, 5'd0, 32'h100);
      checkOutput("beq_not_taken", {31'd0, branch_taken}, 32'd0);

      tick();
      applyStimulus(1'b1, 14'hA, 32'd9, 32'd8, 32'd3, 1'b1, 6'h10, 5'd0, 32'h100);
      checkOutput("bne_taken", {31'd0, branch_taken}, 32'd1);

      tick();
      applyStimulus(1'b1, 14'h9, 32'd9, 32'd9, 32'd3, 1'b1, 6'h00, 5'd0, 32'h100);
      checkOutput("beq_no_br_bit", {31'd0, branch_taken}, 32'd0);

      tick();
      applyStimulus(1'b1, 14'h8, 32'h0001_0001, 32'h0001_0001, 32'd0, 1'b0, 6'h08, 5'd7, 32'h0);
      checkOutput("mul_issue_out_valid", {31'd0, out_valid}, 32'd0);
      waitMul(n);
      checkOutput("mul_stall_cycles", n, 32'd33);
      checkOutput("mul_done_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("mul_result", alu_result, 32'h0002_0001);
      checkOutput("mul_rgd", {27'd0, rgD_index_out}, 32'd7);
      checkOutput("mul_control_out", {26'd0, control_out}, 32'h08);
      checkOutput("mul_store_data", store_data, 32'h0001_0001);

      tick();
      applyStimulus(1'b0, 14'h8, 32'h0001_0001, 32'h0001_0001, 32'd0, 1'b0, 6'h08, 5'd7, 32'h0);
      checkOutput("bubble_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("bubble_control_out", {26'd0, control_out}, 32'd0);
      checkOutput("bubble_stall", {31'd0, stall}, 32'd0);
      tick();
      checkOutput("no_duplicate", {31'd0, out_valid}, 32'd0);

      applyStimulus(1'b1, 14'h8, 32'd7, 32'd0, 32'd6, 1'b1, 6'h08, 5'd9, 32'h0);
      waitMul(n);
      checkOutput("mul2_stall_cycles", n, 32'd33);
      checkOutput("mul2_result", alu_result, 32'd42);
      tick();
      applyStimulus(1'b1, 14'h0, 32'd100, 32'd23, 32'd0, 1'b0, 6'h08, 5'd2, 32'h0);
      checkOutput("add_after_mul_result", alu_result, 32'd123);
      checkOutput("add_after_mul_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("add_after_mul_stall", {31'd0, stall}, 32'd0);

      tick();
      applyStimulus(1'b1, 14'h8, 32'd3, 32'd3, 32'd0, 1'b0, 6'h08, 5'd5, 32'h0);
      for (int i = 0; i < 11; i++) tick();
      checkOutput("pre_reset_busy_stall", {31'd0, stall}, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("midmul_reset_stall", {31'd0, stall}, 32'd0);
      checkOutput("midmul_reset_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("midmul_reset_ctrl", {26'd0, control_out}, 32'd0);
      tick();
      applyStimulus(1'b0, 14'h0, 32'd0, 32'd0, 32'd0, 1'b0, 6'h00, 5'd0, 32'h0);
      tick();
      reset = 1'b1;
      tick();
      applyStimulus(1'b1, 14'h0, 32'd1, 32'd2, 32'd0, 1'b0, 6'h08, 5'd1, 32'h0);
      checkOutput("post_reset_add", alu_result, 32'd3);
      checkOutput("post_reset_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("post_reset_stall", {31'd0, stall}, 32'd0);
      tick();
      checkOutput("post_reset_no_stray", {31'd0, out_valid & ~stall}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
